// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution result writer.
//   DATA_W  : width of one convolution result
//   NUM_OUT : results per frame (2x2 output map)
//   IDX_W   : width of the buffer write index
//   state_e : writer FSM states
package conv_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned NUM_OUT = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage : conv_pkg

// File: rtl/conv_dff.sv
// D flip-flop primitive with synchronous active-high reset to zero.
//   clk   : clock, rising edge
//   reset : synchronous clear
//   d     : next value
//   q     : registered value
module conv_dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule : conv_dff

// File: rtl/wr_index_counter.sv
// Wrapping up-counter for the frame buffer write index.
//   clk   : clock, rising edge
//   reset : synchronous clear to 0
//   en    : increment (wraps at 2^W)
//   clr   : synchronous clear to 0, priority over en
//   cnt_o : current index
module wr_index_counter #(
  parameter int unsigned W = conv_pkg::IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next index: clear wins, otherwise count on enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  conv_dff #(.W(W)) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  assign cnt_o = cnt_q;

endmodule : wr_index_counter

// File: rtl/conv_result_writer.sv
// Collects NUM_OUT convolution results into a frame buffer, tracks the
// maximum result on the fly and holds the complete frame until acknowledged.
//   clk, reset   : clock and synchronous active-high reset
//   in_valid     : in_data carries a result
//   in_data      : unsigned convolution result
//   in_ready     : writer accepts in_data (FILL state)
//   out_valid    : complete frame held (HOLD state)
//   out_frame    : entry k at bits [k*DATA_W +: DATA_W]
//   out_ack      : consumer takes the held frame
//   out_max      : largest result in the frame
//   out_max_idx  : index of out_max, lowest index on ties
//   frame_done   : one-cycle pulse when out_valid rises
module conv_result_writer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W  = conv_pkg::DATA_W,
  parameter int unsigned NUM_OUT = conv_pkg::NUM_OUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [NUM_OUT*DATA_W-1:0] out_frame,
  input  logic                      out_ack,
  output logic [DATA_W-1:0]         out_max,
  output logic [IDX_W-1:0]          out_max_idx,
  output logic                      frame_done
);

  state_e             state_q;
  state_e             state_d;
  logic [IDX_W-1:0]   wr_idx;
  logic               xfer;
  logic               last_xfer;
  logic               ack_take;
  logic [DATA_W-1:0]  buf_q [NUM_OUT];
  logic [DATA_W-1:0]  max_q;
  logic [IDX_W-1:0]   max_idx_q;
  logic               frame_done_q;

  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (wr_idx == IDX_W'(NUM_OUT - 1));
  assign ack_take  = (state_q == HOLD) && out_ack;

  // Write index; cleared on acknowledge so the next frame starts at entry 0.
  wr_index_counter #(.W(IDX_W)) u_wr_idx (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .clr   (ack_take),
    .cnt_o (wr_idx)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (last_xfer) state_d = HOLD;
      HOLD:    if (out_ack)   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      FILL:    in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Frame buffer; only written on accepted transfers, so HOLD keeps it stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_OUT); k++) begin
        buf_q[k] <= '0;
      end
    end else if (xfer) begin
      buf_q[wr_idx] <= in_data;
    end
  end

  // Running max: first transfer loads, later ones replace only if strictly
  // greater, which yields the lowest index on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q     <= '0;
      max_idx_q <= '0;
    end else if (xfer) begin
      if (wr_idx == '0 || in_data > max_q) begin
        max_q     <= in_data;
        max_idx_q <= wr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_xfer;
    end
  end

  // Flatten the buffer onto the output bus.
  always_comb begin
    out_frame = '0;
    for (int k = 0; k < int'(NUM_OUT); k++) begin
      out_frame[k*DATA_W +: DATA_W] = buf_q[k];
    end
  end

  assign out_max     = max_q;
  assign out_max_idx = max_idx_q;
  assign frame_done  = frame_done_q;

endmodule : conv_result_writer

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer: directed scenarios followed by
// random traffic, all compared against a frame-level reference model.
module tb_conv_result_writer;

  localparam int unsigned DW = 12;
  localparam int unsigned NO = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              out_valid;
  logic [NO*DW-1:0]  out_frame;
  logic              out_ack;
  logic [DW-1:0]     out_max;
  logic [1:0]        out_max_idx;
  logic              frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Reference model: the results collected so far and whether a frame is held.
  logic [DW-1:0] m_buf [NO];
  int            m_cnt;
  bit            m_hold;
  bit            m_done;

  conv_result_writer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_frame   (out_frame),
    .out_ack     (out_ack),
    .out_max     (out_max),
    .out_max_idx (out_max_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ack, input bit rst);
    logic [NO*DW-1:0] ef;
    logic [DW-1:0]    em;
    int               ei;
    in_valid = v;
    in_data  = d;
    out_ack  = ack;
    reset    = rst;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < int'(NO); k++) m_buf[k] = '0;
      m_cnt = 0; m_hold = 0; m_done = 0;
    end else if (m_hold) begin
      m_done = 0;
      if (ack) begin m_hold = 0; m_cnt = 0; end
    end else begin
      m_done = 0;
      if (v) begin
        m_buf[m_cnt] = d;
        m_cnt++;
        if (m_cnt == int'(NO)) begin m_hold = 1; m_done = 1; m_cnt = 0; end
      end
    end
    #1;
    for (int k = 0; k < int'(NO); k++) ef[k*DW +: DW] = m_buf[k];
    chk("in_ready",   64'(in_ready),   64'(!m_hold));
    chk("out_valid",  64'(out_valid),  64'(m_hold));
    chk("frame_done", 64'(frame_done), 64'(m_done));
    chk("out_frame",  64'(out_frame),  64'(ef));
    if (m_hold) begin
      em = m_buf[0]; ei = 0;
      for (int k = 1; k < int'(NO); k++) if (m_buf[k] > em) begin em = m_buf[k]; ei = k; end
      chk("out_max",     64'(out_max),     64'(em));
      chk("out_max_idx", 64'(out_max_idx), 64'(ei));
    end
    if (frame_done) n_done++;
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic ack_frame();
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int done0;
    in_valid = 1'b0; in_data = '0; out_ack = 1'b0; reset = 1'b1;
    for (int k = 0; k < int'(NO); k++) m_buf[k] = '0;
    m_cnt = 0; m_hold = 0; m_done = 0;
    @(negedge clk);

    // Reset state.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 12'hABC, 1'b1, 1'b1);
    chk("rst_max",     64'(out_max),     64'h0);
    chk("rst_max_idx", 64'(out_max_idx), 64'h0);
    chk("rst_frame",   64'(out_frame),   64'h0);

    // Frame capture, back to back.
    done0 = n_done;
    send(12'h010); send(12'h0A0); send(12'h003);
    chk("pre_valid", 64'(out_valid), 64'h0);
    send(12'h0A0);
    chk("cap_valid",   64'(out_valid),   64'h1);
    chk("cap_frame",   64'(out_frame),   64'h0A0_003_0A0_010);
    chk("cap_max",     64'(out_max),     64'h0A0);
    chk("cap_max_idx", 64'(out_max_idx), 64'h1);
    idle(2);
    chk("cap_done_pulses", 64'(n_done - done0), 64'h1);

    // Backpressure in HOLD, then acknowledge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 12'hFFF, 1'b0, 1'b0);
    chk("bp_frame", 64'(out_frame), 64'h0A0_003_0A0_010);
    ack_frame();
    chk("bp_ready", 64'(in_ready), 64'h1);

    // Gapped input.
    send(12'h010); idle(int'($urandom_range(0, 3)));
    send(12'h0A0); idle(int'($urandom_range(0, 3)));
    send(12'h003); idle(3);
    chk("gap_pre_valid", 64'(out_valid), 64'h0);
    send(12'h0A0);
    chk("gap_frame",   64'(out_frame),   64'h0A0_003_0A0_010);
    chk("gap_max_idx", 64'(out_max_idx), 64'h1);
    ack_frame();

    // Reset mid-frame.
    done0 = n_done;
    send(12'h055); send(12'h066);
    cycle(1'b1, 12'h077, 1'b0, 1'b1);
    send(12'd1); send(12'd2); send(12'd3); send(12'd4);
    chk("rmf_frame",   64'(out_frame),   64'h004_003_002_001);
    chk("rmf_max",     64'(out_max),     64'h4);
    chk("rmf_max_idx", 64'(out_max_idx), 64'h3);
    chk("rmf_done_pulses", 64'(n_done - done0), 64'h1);
    // Reset while holding discards the frame.
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Ack in FILL ignored, then extreme values.
    cycle(1'b0, '0, 1'b1, 1'b0);
    send(12'hFFF);
    cycle(1'b1, 12'h000, 1'b1, 1'b0);
    send(12'hFFF); send(12'h000);
    chk("ext_frame",   64'(out_frame),   64'h000_FFF_000_FFF);
    chk("ext_max",     64'(out_max),     64'hFFF);
    chk("ext_max_idx", 64'(out_max_idx), 64'h0);

    // Back-to-back frames: data offered with the ack is not taken.
    cycle(1'b1, 12'h111, 1'b1, 1'b0);
    send(12'h222); send(12'h333); send(12'h444); send(12'h555);
    chk("b2b_frame", 64'(out_frame), 64'h555_444_333_222);
    ack_frame();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), DW'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_conv_result_writer
